// File: rtl/gol_gen_sequencer.sv
// -----------------------------------------------------------------------------
// gol_gen_sequencer
//
// Purpose:
//   Sequences one Game-of-Life generation per go request. For every row r the
//   sequencer fetches rows r-1, r and r+1 from the front buffer, with toroidal
//   wrap. It then pulses the cell-compute engine and writes the result row to
//   the back buffer. After the last row it waits for display vblank. It then
//   swaps front and back buffers and bumps the generation counter.
//   A 1-deep go queue absorbs one request that arrives while a generation runs.
//
// Parameters:
//   ROWS    field height in rows (>= 3)
//   ROW_AW  row address width, derived from ROWS (do not override)
//   GEN_W   generation counter width
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   i_go          1-cycle request to compute the next generation
//   i_vblank      display idle; buffer swap permitted
//   o_rd_req      front-buffer row read request, held until i_rd_ack
//   o_rd_row      row address for the read
//   i_rd_ack      read accepted; row data handed to the compute engine
//   o_calc_start  1-cycle pulse: engine may start on the three fetched rows
//   i_calc_done   engine finished; result row valid
//   o_wr_en       1-cycle back-buffer write strobe
//   o_wr_row      row address for the write
//   o_front_sel   buffer currently displayed/read (0 = A, 1 = B)
//   o_busy        high in every state except IDLE
//   o_gen_cnt     completed generations, wrapping
//   o_go_dropped  1-cycle pulse: a go request was discarded
// -----------------------------------------------------------------------------
module gol_gen_sequencer #(
  parameter int ROWS   = 32,
  parameter int ROW_AW = $clog2(ROWS),
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_go,
  input  logic              i_vblank,
  output logic              o_rd_req,
  output logic [ROW_AW-1:0] o_rd_row,
  input  logic              i_rd_ack,
  output logic              o_calc_start,
  input  logic              i_calc_done,
  output logic              o_wr_en,
  output logic [ROW_AW-1:0] o_wr_row,
  output logic              o_front_sel,
  output logic              o_busy,
  output logic [GEN_W-1:0]  o_gen_cnt,
  output logic              o_go_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_PREV,
    S_RD_CUR,
    S_RD_NEXT,
    S_CALC,
    S_WRITE,
    S_WAIT_SWAP
  } state_e;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  state_e              state_q, state_d;
  logic [ROW_AW-1:0]   row_q, row_d;
  logic                front_sel_q, front_sel_d;
  logic [GEN_W-1:0]    gen_cnt_q, gen_cnt_d;
  logic                pending_q, pending_d;
  logic                calc_first_q, calc_first_d;
  logic                go_dropped_q, go_dropped_d;

  // Neighbour rows with toroidal wrap.
  logic [ROW_AW-1:0]   row_prev, row_next;
  logic                busy;

  assign row_prev = (row_q == '0)       ? LAST_ROW : row_q - 1'b1;
  assign row_next = (row_q == LAST_ROW) ? '0       : row_q + 1'b1;
  assign busy     = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d      = state_q;
    row_d        = row_q;
    front_sel_d  = front_sel_q;
    gen_cnt_d    = gen_cnt_q;
    pending_d    = pending_q;
    calc_first_d = calc_first_q;
    go_dropped_d = 1'b0;

    o_rd_req     = 1'b0;
    o_rd_row     = '0;
    o_calc_start = 1'b0;
    o_wr_en      = 1'b0;

    // Go queue while busy. The swap cycle is still WAIT_SWAP, so a go there
    // is queued and starts the next generation right after the swap.
    if (i_go && busy) begin
      if (pending_q) begin
        go_dropped_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_go || pending_q) begin
          state_d   = S_RD_PREV;
          row_d     = '0;
          // A queued go starts now. A fresh go in the same cycle takes its
          // place in the queue instead of being lost.
          pending_d = pending_q && i_go;
        end
      end

      S_RD_PREV: begin
        o_rd_req = 1'b1;
        o_rd_row = row_prev;
        if (i_rd_ack) state_d = S_RD_CUR;
      end

      S_RD_CUR: begin
        o_rd_req = 1'b1;
        o_rd_row = row_q;
        if (i_rd_ack) state_d = S_RD_NEXT;
      end

      S_RD_NEXT: begin
        o_rd_req = 1'b1;
        o_rd_row = row_next;
        if (i_rd_ack) begin
          state_d      = S_CALC;
          calc_first_d = 1'b1;
        end
      end

      S_CALC: begin
        // The engine cannot answer in the same cycle as its start pulse.
        // Done is therefore ignored in the first CALC cycle.
        if (calc_first_q) begin
          o_calc_start = 1'b1;
          calc_first_d = 1'b0;
        end else if (i_calc_done) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        o_wr_en = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_WAIT_SWAP;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_RD_PREV;
        end
      end

      S_WAIT_SWAP: begin
        if (i_vblank) begin
          front_sel_d = ~front_sel_q;
          gen_cnt_d   = gen_cnt_q + 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments. All of them then update
    // together from the values computed before the edge.
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      front_sel_q  <= 1'b0;
      gen_cnt_q    <= '0;
      pending_q    <= 1'b0;
      calc_first_q <= 1'b0;
      go_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      front_sel_q  <= front_sel_d;
      gen_cnt_q    <= gen_cnt_d;
      pending_q    <= pending_d;
      calc_first_q <= calc_first_d;
      go_dropped_q <= go_dropped_d;
    end
  end

  assign o_wr_row     = row_q;
  assign o_front_sel  = front_sel_q;
  assign o_busy       = busy;
  assign o_gen_cnt    = gen_cnt_q;
  assign o_go_dropped = go_dropped_q;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gol_gen_sequencer
//
// Self-checking bench for gol_gen_sequencer with ROWS=4.
// The main instance runs generations, read stalls, vblank stalls, the go
// queue and reset during CALC. Expected read and write rows are pushed to
// queues when a generation is requested. A negedge monitor pops and compares
// those queues. A second instance with GEN_W=2 checks counter wrap.
// -----------------------------------------------------------------------------
module tb_gol_gen_sequencer;

  localparam int ROWS   = 4;
  localparam int ROW_AW = $clog2(ROWS);
  localparam int GEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_go, i_vblank, i_rd_ack, i_calc_done;
  logic              o_rd_req, o_calc_start, o_wr_en;
  logic              o_front_sel, o_busy, o_go_dropped;
  logic [ROW_AW-1:0] o_rd_row, o_wr_row;
  logic [GEN_W-1:0]  o_gen_cnt;

  logic              go2;
  logic              rd_req2, calc_start2, wr_en2, front_sel2, busy2, go_dropped2;
  logic [ROW_AW-1:0] rd_row2, wr_row2;
  logic [1:0]        gen_cnt2;

  always #5 clk = ~clk;

  gol_gen_sequencer #(.ROWS(ROWS), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_vblank(i_vblank),
    .o_rd_req(o_rd_req), .o_rd_row(o_rd_row), .i_rd_ack(i_rd_ack),
    .o_calc_start(o_calc_start), .i_calc_done(i_calc_done),
    .o_wr_en(o_wr_en), .o_wr_row(o_wr_row), .o_front_sel(o_front_sel),
    .o_busy(o_busy), .o_gen_cnt(o_gen_cnt), .o_go_dropped(o_go_dropped)
  );

  gol_gen_sequencer #(.ROWS(ROWS), .GEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_go(go2), .i_vblank(1'b1),
    .o_rd_req(rd_req2), .o_rd_row(rd_row2), .i_rd_ack(1'b1),
    .o_calc_start(calc_start2), .i_calc_done(1'b1),
    .o_wr_en(wr_en2), .o_wr_row(wr_row2), .o_front_sel(front_sel2),
    .o_busy(busy2), .o_gen_cnt(gen_cnt2), .o_go_dropped(go_dropped2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int exp_rd[$];
  int exp_wr[$];
  int exp_calc   = 0;
  int calc_seen  = 0;
  int drop_seen  = 0;
  logic calc_prev = 1'b0;

  task automatic push_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      exp_rd.push_back((r + ROWS - 1) % ROWS);
      exp_rd.push_back(r);
      exp_rd.push_back((r + 1) % ROWS);
      exp_wr.push_back(r);
      exp_calc++;
    end
  endtask

  always @(negedge clk) begin
    if (o_rd_req === 1'b1 && i_rd_ack === 1'b1) begin
      if (exp_rd.size() == 0) check("rd_unexpected", exp_rd.size(), 1);
      else check("rd_row", o_rd_row, exp_rd.pop_front());
    end
    if (o_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
      else check("wr_row", o_wr_row, exp_wr.pop_front());
    end
    if (o_calc_start === 1'b1) begin
      calc_seen++;
      check("calc_width", calc_prev, 0);
    end
    if (o_go_dropped === 1'b1) drop_seen++;
    calc_prev = (o_calc_start === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
  endtask

  task automatic wait_gen(input logic [GEN_W-1:0] target, input int budget);
    int n = 0;
    while (o_gen_cnt !== target && n < budget) begin
      tick();
      n++;
    end
    check("gen_cnt_reached", o_gen_cnt, target);
  endtask

  logic [GEN_W-1:0] exp_gen;
  logic             exp_front;

  initial begin
    int   n;
    int   cs;
    logic [1:0] e2;

    rst = 1'b1; i_go = 1'b0; i_vblank = 1'b1; i_rd_ack = 1'b1;
    i_calc_done = 1'b1; go2 = 1'b0;
    exp_gen = '0; exp_front = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",    o_busy, 0);
    check("rst_rd_req",  o_rd_req, 0);
    check("rst_rd_row",  o_rd_row, 0);
    check("rst_calc",    o_calc_start, 0);
    check("rst_wr_en",   o_wr_en, 0);
    check("rst_wr_row",  o_wr_row, 0);
    check("rst_front",   o_front_sel, 0);
    check("rst_gen",     o_gen_cnt, 0);
    check("rst_dropped", o_go_dropped, 0);
    check("rst_gen2",    gen_cnt2, 0);

    // Test 1: zero-wait generation, go-to-swap latency
    push_rows(0, ROWS - 1);
    pulse_go();
    check("t1_rd_req_next", o_rd_req, 1);
    check("t1_rd_row_first", o_rd_row, ROWS - 1);
    n = 0;
    while (o_front_sel === exp_front && n < 100) begin
      tick();
      n++;
    end
    check("t1_go_to_swap", n, 25);
    exp_gen++; exp_front = ~exp_front;
    check("t1_front", o_front_sel, exp_front);
    check("t1_gen",   o_gen_cnt, exp_gen);
    check("t1_busy",  o_busy, 0);

    // Test 2: read ack stall in RD_CUR
    push_rows(0, ROWS - 1);
    pulse_go();
    tick();                       // RD_PREV acked, now in RD_CUR
    i_rd_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_hold", o_rd_req, 1);
      check("t2_row_hold", o_rd_row, 0);
      tick();
    end
    check("t2_row_still", o_rd_row, 0);
    i_rd_ack = 1'b1;
    exp_gen++; exp_front = ~exp_front;
    wait_gen(exp_gen, 100);
    check("t2_front", o_front_sel, exp_front);

    // Test 3: vblank held low after the last write
    i_vblank = 1'b0;
    push_rows(0, ROWS - 1);
    pulse_go();
    n = 0;
    while (!(o_wr_en === 1'b1 && o_wr_row == ROW_AW'(ROWS - 1)) && n < 100) begin
      tick();
      n++;
    end
    check("t3_last_wr", o_wr_en, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("t3_front_hold", o_front_sel, exp_front);
      check("t3_busy_hold", o_busy, 1);
      tick();
    end
    i_vblank = 1'b1;
    tick();
    exp_gen++; exp_front = ~exp_front;
    check("t3_front_swap", o_front_sel, exp_front);
    check("t3_gen", o_gen_cnt, exp_gen);
    check("t3_busy", o_busy, 0);

    // Test 4: go queue, one pending and two dropped
    drop_seen = 0;
    push_rows(0, ROWS - 1);
    pulse_go();
    repeat (3) tick();
    push_rows(0, ROWS - 1);       // this go is queued
    pulse_go();
    repeat (3) tick();
    pulse_go();                   // dropped
    repeat (3) tick();
    pulse_go();                   // dropped
    exp_gen++; exp_front = ~exp_front;
    wait_gen(exp_gen, 100);
    check("t4_idle_gap", o_busy, 0);
    check("t4_front1", o_front_sel, exp_front);
    tick();
    check("t4_auto_busy", o_busy, 1);
    check("t4_auto_rd", o_rd_req, 1);
    check("t4_auto_row", o_rd_row, ROWS - 1);
    exp_gen++; exp_front = ~exp_front;
    wait_gen(exp_gen, 100);
    check("t4_front2", o_front_sel, exp_front);
    check("t4_dropped", drop_seen, 2);
    repeat (3) tick();
    check("t4_no_third", o_busy, 0);

    // Test 5: reset during CALC of row 2
    push_rows(0, 1);
    exp_rd.push_back(1); exp_rd.push_back(2); exp_rd.push_back(3);
    exp_calc++;
    pulse_go();
    cs = 0; n = 0;
    while (cs < 3 && n < 100) begin
      if (o_calc_start === 1'b1) cs++;
      if (cs < 3) begin
        tick();
        n++;
      end
    end
    check("t5_calc_row2", cs, 3);
    rst = 1'b1;
    tick();
    check("t5_busy",    o_busy, 0);
    check("t5_rd_req",  o_rd_req, 0);
    check("t5_rd_row",  o_rd_row, 0);
    check("t5_calc",    o_calc_start, 0);
    check("t5_wr_en",   o_wr_en, 0);
    check("t5_wr_row",  o_wr_row, 0);
    check("t5_front",   o_front_sel, 0);
    check("t5_gen",     o_gen_cnt, 0);
    check("t5_dropped", o_go_dropped, 0);
    rst = 1'b0;
    exp_gen = '0; exp_front = 1'b0;
    repeat (3) tick();
    check("t5_stay_idle", o_busy, 0);
    push_rows(0, ROWS - 1);
    pulse_go();
    exp_gen++; exp_front = ~exp_front;
    wait_gen(exp_gen, 100);
    check("t5_front_after", o_front_sel, exp_front);

    // Test 6: GEN_W=2 counter wrap
    e2 = 2'd0;
    for (int k = 0; k < 5; k++) begin
      go2 = 1'b1;
      tick();
      go2 = 1'b0;
      e2 = e2 + 2'd1;
      n = 0;
      while (gen_cnt2 !== e2 && n < 60) begin
        tick();
        n++;
      end
      check("t6_gen_wrap", gen_cnt2, e2);
    end

    // Scoreboard drain
    repeat (2) tick();
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("calc_pulses", calc_seen, exp_calc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
